// File: rtl/scr1_scu_cmd_seq.sv
// SCU system-control chain command sequencer: arbitrates two requesters and
// serializes each command into the 8-bit sysctrl DR, optionally reading it back.
module scr1_scu_cmd_seq #(
  parameter bit          SCR1_SCU_SEQ_READBACK = 1'b1,
  parameter int unsigned SCR1_SCU_SEQ_DR_WIDTH = 8
) (
  input  logic       clk,
  input  logic       pwrup_rst_n_sync,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_op,
  input  logic [3:0] req_addr,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic       rsp_id,
  output logic [3:0] rsp_data,
  input  logic       tapc_owner,
  output logic       seq_busy,
  output logic       ch_sel,
  output logic       ch_id,
  output logic       ch_capture,
  output logic       ch_shift,
  output logic       ch_update,
  output logic       ch_tdi,
  input  logic       ch_tdo
);

  // state     | meaning
  // IDLE      | arbitrate; chain released (TAPC may own it)
  // SHIFT_IN  | shift command DR in, LSB first, 8 cycles
  // UPDATE    | apply the command in the SCU
  // CAPTURE   | load post-operation register value into DR
  // SHIFT_OUT | shift DR out, sampling ch_tdo, 8 cycles
  // RESP      | one-cycle response pulse

  localparam int unsigned DRW      = SCR1_SCU_SEQ_DR_WIDTH;
  localparam logic [2:0]  CNT_LAST = 3'(DRW - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_UPDATE,
    ST_CAPTURE,
    ST_SHIFT_OUT,
    ST_RESP
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       cnt;
  logic [DRW-1:0]   cmd_sr;
  logic [3:0]       rx_data;
  logic             rr_last;
  logic             rsp_id_r;
  logic [1:0]       eligible;
  logic             grant;
  logic             hs;
  logic [1:0]       sel_op;
  logic [1:0]       sel_addr;
  logic [3:0]       sel_data;

  always_comb begin
    eligible   = req_valid & {2{~tapc_owner}};
    grant      = (eligible == 2'b11) ? ~rr_last : eligible[1];
    sel_op     = grant ? req_op[3:2]   : req_op[1:0];
    sel_addr   = grant ? req_addr[3:2] : req_addr[1:0];
    sel_data   = grant ? req_data[7:4] : req_data[3:0];
    hs         = 1'b0;
    req_ready  = 2'b00;
    ch_sel     = 1'b0;
    ch_capture = 1'b0;
    ch_shift   = 1'b0;
    ch_update  = 1'b0;
    ch_tdi     = 1'b0;
    state_nxt  = state;
    case (state)
      ST_IDLE: begin
        if (|eligible) begin
          hs        = 1'b1;
          req_ready = grant ? 2'b10 : 2'b01;
          state_nxt = ST_SHIFT_IN;
        end
      end
      ST_SHIFT_IN: begin
        ch_sel   = 1'b1;
        ch_shift = 1'b1;
        ch_tdi   = cmd_sr[0];
        if (cnt == CNT_LAST) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        ch_sel    = 1'b1;
        ch_update = 1'b1;
        state_nxt = SCR1_SCU_SEQ_READBACK ? ST_CAPTURE : ST_RESP;
      end
      ST_CAPTURE: begin
        ch_sel     = 1'b1;
        ch_capture = 1'b1;
        state_nxt  = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        ch_sel   = 1'b1;
        ch_shift = 1'b1;
        if (cnt == CNT_LAST) state_nxt = ST_RESP;
      end
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge pwrup_rst_n_sync) begin
    if (!pwrup_rst_n_sync) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      cmd_sr   <= '0;
      rx_data  <= 4'h0;
      rr_last  <= 1'b1;
      rsp_id_r <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ST_SHIFT_IN || state == ST_SHIFT_OUT) ? cnt + 3'd1 : 3'd0;
      if (hs) begin
        cmd_sr   <= {sel_data, sel_addr, sel_op};
        rr_last  <= grant;
        rsp_id_r <= grant;
      end else if (state == ST_SHIFT_IN) begin
        cmd_sr <= {1'b0, cmd_sr[DRW-1:1]};
      end
      // Only DR bits 7:4 (the data field) are kept; addr/op echo is discarded.
      if (state == ST_SHIFT_OUT && cnt[2]) rx_data[cnt[1:0]] <= ch_tdo;
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = SCR1_SCU_SEQ_READBACK ? rx_data : 4'h0;
  assign seq_busy  = (state != ST_IDLE);
  assign ch_id     = 1'b0;

endmodule
